// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Two requesters (ALU path = 0, load path = 1) share the port under a
// round-robin policy with a valid/ready handshake. The winning write is
// registered onto wa/we/wd, the in-flight write is forwarded to the two
// read ports, and cycles where both requesters contend are counted.
module regfile_wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [4:0]       req0_addr,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_addr,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [4:0]       wa,
  output logic             we,
  output logic [WIDTH-1:0] wd,
  output logic             grant_id,
  input  logic [4:0]       ra0,
  input  logic [4:0]       ra1,
  output logic             fwd0_hit,
  output logic             fwd1_hit,
  output logic [WIDTH-1:0] fwd_data,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             prio_q, prio_d;
  logic [4:0]       wa_q, wa_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic             gid_q, gid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic grant0, grant1, bothValid;

  // Pick the winner: a lone requester wins, a tie goes to the priority
  // pointer, and reset suppresses every grant so nothing is half-accepted.
  always_comb begin
    bothValid = req0_valid & req1_valid;
    grant0    = !rst && req0_valid && (!req1_valid || !prio_q);
    grant1    = !rst && req1_valid && (!req0_valid || prio_q);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Next-state for the write port, the pointer and the contention counter.
  // Writes to r0 still consume a grant but never raise the write enable.
  always_comb begin
    prio_d = prio_q;
    wa_d   = wa_q;
    wd_d   = wd_q;
    gid_d  = gid_q;
    we_d   = 1'b0;
    cnt_d  = cnt_q;
    if (grant0) begin
      prio_d = 1'b1;
      wa_d   = req0_addr;
      wd_d   = req0_data;
      gid_d  = 1'b0;
      we_d   = (req0_addr != 5'd0);
    end else if (grant1) begin
      prio_d = 1'b0;
      wa_d   = req1_addr;
      wd_d   = req1_data;
      gid_d  = 1'b1;
      we_d   = (req1_addr != 5'd0);
    end
    if (bothValid && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // State register with synchronous reset that wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
      wa_q   <= 5'd0;
      we_q   <= 1'b0;
      wd_q   <= '0;
      gid_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prio_q <= prio_d;
      wa_q   <= wa_d;
      we_q   <= we_d;
      wd_q   <= wd_d;
      gid_q  <= gid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wa           = wa_q;
  assign we           = we_q;
  assign wd           = wd_q;
  assign grant_id     = gid_q;
  assign conflict_cnt = cnt_q;

  // Forward the write the register file has not yet committed.
  assign fwd0_hit = we_q && (wa_q == ra0);
  assign fwd1_hit = we_q && (wa_q == ra1);
  assign fwd_data = wd_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 32-entry register file between two writeback requesters: requester 0 is the ALU/single-cycle path and requester 1 is the load/multi-cycle path. Arbitration is round-robin with a valid/ready handshake. The block registers the winning write into the register file's `wa`/`we`/`wd` inputs, exposes that in-flight write to the two read ports as forwarding, and counts arbitration conflicts. It sits between the execute/memory stages and the register file.

## Interface
- `WIDTH`, default 32: data width; must match the register file width.
- `CNT_W`, default 16: width of the conflict counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req0_valid` in 1: requester 0 has a write pending.
- `req0_addr` in 5: requester 0 destination register.
- `req0_data` in WIDTH: requester 0 write data.
- `req0_ready` out 1: requester 0 accepted this cycle (combinational).
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `wa` out 5: register file write address (registered).
- `we` out 1: register file write enable (registered).
- `wd` out WIDTH: register file write data (registered).
- `grant_id` out 1: requester that produced the current `wa`/`we`/`wd` (registered).
- `ra0` in 5, `ra1` in 5: the register file read addresses, snooped for forwarding.
- `fwd0_hit` out 1, `fwd1_hit` out 1: the in-flight write targets `ra0`/`ra1`.
- `fwd_data` out WIDTH: equals `wd`; valid when either hit is asserted.
- `conflict_cnt` out CNT_W: saturating count of conflict cycles.

## Operation
- Priority pointer `p`, one bit, reset 0; requester `p` wins a tie.
- Grant rules, evaluated every cycle:
  - Only one valid: that requester wins.
  - Both valid: requester `p` wins.
  - Neither valid: no grant.
- `reqK_ready` = 1 exactly when requester K wins and `rst`=0. At most one ready is high per cycle.
- On a grant to K:
  - `p` becomes the other requester (!K).
  - `wa`, `wd` load the request's address and data; `grant_id` loads K.
  - `we` loads 1 if the address is nonzero, else 0.
- Writes to r0 are handshaken and consume the grant, but never assert `we`.
- With no grant: `we` loads 0; `wa`, `wd`, `grant_id` hold their values; `p` holds.
- Requester rule: once `valid` is asserted, `addr`, `data` and `valid` stay stable until `ready`. The bench checks this; the block does not latch unaccepted requests.
- Forwarding:
  - `fwdN_hit` = `we` && (`wa` == `raN`).
  - `fwd_data` = `wd`.
  - Both are combinational from registered state. They cover the cycle in which the register file has not yet committed the write.
- Conflict counter: increments every cycle in which both requesters are valid; saturates at all-ones and never wraps.

## Timing
- Reset values: `we`=0, `wa`=0, `wd`=0, `grant_id`=0, `p`=0, `conflict_cnt`=0, both `ready`=0, both `fwd_hit`=0.
- Reset behaviour:
  - `rst` overrides everything, including a handshake in the same cycle.
  - A request that sees `rst` is not accepted and must be re-presented.
- Latency:
  - Accept in cycle N.
  - `we`/`wa`/`wd` valid in cycle N+1.
  - Register file commits at the end of N+1; the value is readable from the register file in N+2.
  - Forwarding covers cycle N+1.
- Throughput: one write per cycle. Under continuous dual requests, the grants alternate 0,1,0,1,…
- Back-to-back writes to the same address: the later grant overwrites in order. Forwarding always reflects the most recent accepted write.
- A requester stalled by a conflict waits at most one cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles with both requesters valid.
  - Required: both readies 0, `we`=0, `conflict_cnt`=0, all outputs at reset values.
- **Single requester:** `req0` writes 0xDEADBEEF to r5 in cycle N.
  - Required: `req0_ready`=1 in N; in N+1, `we`=1, `wa`=5, `wd`=0xDEADBEEF, `grant_id`=0.
  - Required: with `ra1`=5, `fwd1_hit`=1 and `fwd_data`=0xDEADBEEF in N+1.
- **Dual requests:** both requesters valid continuously for 4 cycles after reset, `req0` to r1 and `req1` to r2.
  - Required: grant order 0,1,0,1.
  - Required: `conflict_cnt` = 4 afterwards.
  - Required: each requester has exactly one ready per two cycles.
- **r0 write:** `req1` writes 0x1234 to r0.
  - Required: `req1_ready`=1; next cycle `we`=0 and both `fwd_hit`=0.
  - Required: `p` flips, so `req0` wins the next tie.
- **Reset mid-operation:** both requesters valid and `rst` pulsed for one cycle during alternation.
  - Required: no ready during the `rst` cycle; `p` returns to 0, so `req0` wins the first cycle after `rst` drops.
  - Required: `conflict_cnt` restarts from 0.
- **Saturation:** with `CNT_W`=4, hold both requesters valid for 20 cycles.
  - Required: `conflict_cnt` stops at 15 and does not wrap.
